// File: rtl/jk_cmd_seq.sv
// Command sequencer for a downstream JK flip-flop: queues hold/reset/set/toggle
// commands, drives registered j/k levels, and checks the flop's q against a model.
module jk_cmd_seq #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             j,
   output logic             k,
   input  logic             q_fb,
   output logic             q_exp,
   output logic             busy,
   output logic             done,
   output logic             mismatch
);

   localparam int unsigned OP_W  = 2;
   localparam int unsigned ENT_W = OP_W + LEN_W;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   // command FIFO storage and bookkeeping
   logic [ENT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_d;
   logic             push_c;
   logic             pop_c;
   logic             empty_c;
   logic [ENT_W-1:0] head_c;
   logic [OP_W-1:0]  head_op_c;
   logic [LEN_W-1:0] head_len_c;

   // sequencer state
   state_t           state;
   state_t           state_d;
   logic [OP_W-1:0]  op_r;
   logic [OP_W-1:0]  op_d;
   logic [LEN_W-1:0] rem_r;
   logic [LEN_W-1:0] rem_d;

   assign push_c     = cmd_valid && cmd_ready && !rst;
   assign empty_c    = (count == '0);
   assign head_c     = mem[rd_ptr];
   assign head_op_c  = head_c[ENT_W-1:LEN_W];
   assign head_len_c = head_c[LEN_W-1:0];

   always_comb begin
      count_d = count;
      case ({push_c, pop_c})
         2'b10:   count_d = count + CW'(1);
         2'b01:   count_d = count - CW'(1);
         default: count_d = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= {cmd_op, cmd_len};
      end
   end

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         cmd_ready <= 1'b1;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count     <= count_d;
         cmd_ready <= (count_d != CW'(DEPTH));
      end
   end

   // next-state: load on pop, count down, chain into the next command without a gap
   always_comb begin
      state_d = state;
      op_d    = op_r;
      rem_d   = rem_r;
      pop_c   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty_c) begin
               pop_c   = 1'b1;
               op_d    = head_op_c;
               rem_d   = head_len_c;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (rem_r != '0) begin
               rem_d = rem_r - LEN_W'(1);
            end else if (!empty_c) begin
               pop_c = 1'b1;
               op_d  = head_op_c;
               rem_d = head_len_c;
            end else begin
               op_d    = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // outputs are registered from the next-state so they line up with the drive cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         op_r  <= '0;
         rem_r <= '0;
         j     <= 1'b0;
         k     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         op_r  <= op_d;
         rem_r <= rem_d;
         j     <= (state_d == S_DRIVE) && op_d[1];
         k     <= (state_d == S_DRIVE) && op_d[0];
         busy  <= (state_d == S_DRIVE);
         done  <= (state_d == S_DRIVE) && (rem_d == '0);
      end
   end

   // reference JK model and sticky comparison against the real flop
   always_ff @(posedge clk) begin
      if (rst) begin
         q_exp    <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         if (q_fb != q_exp) begin
            mismatch <= 1'b1;
         end
         case ({j, k})
            2'b01:   q_exp <= 1'b0;
            2'b10:   q_exp <= 1'b1;
            2'b11:   q_exp <= ~q_exp;
            default: q_exp <= q_exp;
         endcase
      end
   end

endmodule
